// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS execute stage:
// ALU select codes, main-control ALUOp classes and R-type funct values.
package mips_pkg;

  typedef logic [2:0] alu_sel_t;
  typedef logic [1:0] alu_op_t;
  typedef logic [5:0] funct_t;

  localparam alu_sel_t ALU_AND  = 3'b000;
  localparam alu_sel_t ALU_OR   = 3'b001;
  localparam alu_sel_t ALU_ADD  = 3'b010;
  localparam alu_sel_t ALU_ZERO = 3'b011;
  localparam alu_sel_t ALU_ANDN = 3'b100;
  localparam alu_sel_t ALU_ORN  = 3'b101;
  localparam alu_sel_t ALU_SUB  = 3'b110;
  localparam alu_sel_t ALU_SLT  = 3'b111;

  localparam alu_op_t ALUOP_ADD   = 2'b00;
  localparam alu_op_t ALUOP_SUB   = 2'b01;
  localparam alu_op_t ALUOP_RTYPE = 2'b10;

  localparam funct_t FN_ADD = 6'b100000;
  localparam funct_t FN_SUB = 6'b100010;
  localparam funct_t FN_AND = 6'b100100;
  localparam funct_t FN_OR  = 6'b100101;
  localparam funct_t FN_SLT = 6'b101010;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: result and zero flag selected by a 3-bit code.
module alu_core
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_sel_t         sel_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  logic slt_s;

  // Signed compare keeps slt correct even when a - b would overflow.
  assign slt_s = ($signed(a_i) < $signed(b_i));

  // Operation select; unused codes still produce a defined value.
  always_comb begin
    result_o = '0;
    case (sel_i)
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_ADD:  result_o = a_i + b_i;
      ALU_ZERO: result_o = '0;
      ALU_ANDN: result_o = a_i & ~b_i;
      ALU_ORN:  result_o = a_i | ~b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, slt_s};
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_execute_stage.sv
// Execute-stage slice: ALU-control decode, ALU, branch-take gate and the
// output register bank feeding data memory, writeback and the PC mux.
module alu_execute_stage
  import mips_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [WIDTH-1:0]   SrcA,
  input  logic [WIDTH-1:0]   SrcB,
  input  logic [FUNCT_W-1:0] InstrFunc,
  input  logic [1:0]         ALUOp,
  input  logic               Branch,
  output logic [2:0]         AluSelect,
  output logic [WIDTH-1:0]   AluResult,
  output logic               Zero,
  output logic               BranchSelect
);

  alu_sel_t         sel_d;
  alu_sel_t         sel_q;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  logic             zero_d;
  logic             zero_q;
  logic             take_d;
  logic             take_q;

  // ALU-control decode; unknown classes and functs fall back to add.
  always_comb begin
    sel_d = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: sel_d = ALU_ADD;
      ALUOP_SUB: sel_d = ALU_SUB;
      ALUOP_RTYPE: begin
        case (InstrFunc)
          FN_ADD:  sel_d = ALU_ADD;
          FN_SUB:  sel_d = ALU_SUB;
          FN_AND:  sel_d = ALU_AND;
          FN_OR:   sel_d = ALU_OR;
          FN_SLT:  sel_d = ALU_SLT;
          default: sel_d = ALU_ADD;
        endcase
      end
      default: sel_d = ALU_ADD;
    endcase
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a_i      (SrcA),
    .b_i      (SrcB),
    .sel_i    (sel_d),
    .result_o (result_d),
    .zero_o   (zero_d)
  );

  assign take_d = Branch & zero_d;

  // Output registers; Zero clears in reset so no branch is taken out of it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sel_q    <= ALU_AND;
      result_q <= '0;
      zero_q   <= 1'b0;
      take_q   <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      take_q   <= take_d;
    end
  end

  assign AluSelect    = sel_q;
  assign AluResult    = result_q;
  assign Zero         = zero_q;
  assign BranchSelect = take_q;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Self-checking bench for alu_execute_stage: directed test-plan cases with
// literal expectations plus randomized traffic against a behavioural model.
module tb_alu_execute_stage;

  localparam int WIDTH = 32;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic [WIDTH-1:0]  SrcA = '0;
  logic [WIDTH-1:0]  SrcB = '0;
  logic [5:0]        InstrFunc = '0;
  logic [1:0]        ALUOp = '0;
  logic              Branch = 1'b0;
  logic [2:0]        AluSelect;
  logic [WIDTH-1:0]  AluResult;
  logic              Zero;
  logic              BranchSelect;

  int checks = 0;
  int failures = 0;

  logic [2:0]        exp_sel = 3'd0;
  logic [WIDTH-1:0]  exp_res = '0;
  logic              exp_zero = 1'b0;
  logic              exp_take = 1'b0;

  alu_execute_stage #(.WIDTH(WIDTH), .FUNCT_W(6)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .SrcA         (SrcA),
    .SrcB         (SrcB),
    .InstrFunc    (InstrFunc),
    .ALUOp        (ALUOp),
    .Branch       (Branch),
    .AluSelect    (AluSelect),
    .AluResult    (AluResult),
    .Zero         (Zero),
    .BranchSelect (BranchSelect)
  );

  always #5 Clk = ~Clk;

  // Spec-level reference: pick the operation from the opcode tables, then
  // evaluate it with plain integer arithmetic.
  function automatic void model(input logic [1:0] op, input logic [5:0] fn,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [2:0] sel, output logic [31:0] r);
    longint la;
    longint lb;
    int sa;
    int sb;
    la = longint'({32'd0, a});
    lb = longint'({32'd0, b});
    sa = int'(a);
    sb = int'(b);
    sel = 3'd2;
    if (op == 2'd1) sel = 3'd6;
    else if (op == 2'd2) begin
      if (fn == 6'd32) sel = 3'd2;
      else if (fn == 6'd34) sel = 3'd6;
      else if (fn == 6'd36) sel = 3'd0;
      else if (fn == 6'd37) sel = 3'd1;
      else if (fn == 6'd42) sel = 3'd7;
      else sel = 3'd2;
    end
    if (sel == 3'd2) r = 32'((la + lb) % 64'sd4294967296);
    else if (sel == 3'd6) r = 32'((la - lb + 64'sd4294967296) % 64'sd4294967296);
    else if (sel == 3'd0) r = a & b;
    else if (sel == 3'd1) r = a | b;
    else r = (sa < sb) ? 32'd1 : 32'd0;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference register bank: same capture/reset behaviour seen from outside.
  always @(posedge Clk or negedge Reset) begin
    logic [2:0]  s;
    logic [31:0] r;
    if (!Reset) begin
      exp_sel  <= 3'd0;
      exp_res  <= '0;
      exp_zero <= 1'b0;
      exp_take <= 1'b0;
    end else begin
      model(ALUOp, InstrFunc, SrcA, SrcB, s, r);
      exp_sel  <= s;
      exp_res  <= r;
      exp_zero <= (r == 32'd0);
      exp_take <= Branch && (r == 32'd0);
    end
  end

  // Every-cycle comparison away from the active edge.
  always @(negedge Clk) begin
    cmp("cyc_sel",  {29'd0, AluSelect},    {29'd0, exp_sel});
    cmp("cyc_res",  AluResult,             exp_res);
    cmp("cyc_zero", {31'd0, Zero},         {31'd0, exp_zero});
    cmp("cyc_take", {31'd0, BranchSelect}, {31'd0, exp_take});
  end

  task automatic op(input logic [1:0] o, input logic [5:0] fn,
                    input logic [31:0] a, input logic [31:0] b, input logic br);
    ALUOp = o; InstrFunc = fn; SrcA = a; SrcB = b; Branch = br;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [2:0]  ms;
    logic [31:0] mr;
    logic [5:0]  fns [6];
    fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
    fns[3] = 6'b100101; fns[4] = 6'b101010; fns[5] = 6'b000000;

    // Pin the model against hand-computed values.
    model(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'h1, ms, mr);
    cmp("model_slt", mr, 32'h1);
    model(2'b01, 6'b000000, 32'h8000_0000, 32'h1, ms, mr);
    cmp("model_sub", mr, 32'h7FFF_FFFF);
    cmp("model_sub_sel", {29'd0, ms}, 32'd6);

    // Reset held with a would-be taken branch on the inputs.
    ALUOp = 2'b01; SrcA = 32'd5; SrcB = 32'd5; Branch = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    cmp("rst_sel", {29'd0, AluSelect}, 32'd0);
    cmp("rst_res", AluResult, 32'd0);
    cmp("rst_zero", {31'd0, Zero}, 32'd0);
    cmp("rst_take", {31'd0, BranchSelect}, 32'd0);
    Reset = 1'b1;
    @(posedge Clk); #1;
    cmp("rel_zero", {31'd0, Zero}, 32'd1);
    cmp("rel_take", {31'd0, BranchSelect}, 32'd1);
    cmp("rel_sel", {29'd0, AluSelect}, 32'd6);

    op(2'b00, 6'd0, 32'h10, 32'hFFFF_FFFC, 1'b0);
    cmp("lw_res", AluResult, 32'hC);
    cmp("lw_sel", {29'd0, AluSelect}, 32'd2);
    cmp("lw_zero", {31'd0, Zero}, 32'd0);

    op(2'b10, 6'b100000, 32'hC, 32'hA, 1'b0); cmp("r_add", AluResult, 32'h16);
    op(2'b10, 6'b100010, 32'hC, 32'hA, 1'b0); cmp("r_sub", AluResult, 32'h2);
    op(2'b10, 6'b100100, 32'hC, 32'hA, 1'b0); cmp("r_and", AluResult, 32'h8);
    op(2'b10, 6'b100101, 32'hC, 32'hA, 1'b0); cmp("r_or", AluResult, 32'hE);
    op(2'b10, 6'b101010, 32'hC, 32'hA, 1'b0); cmp("r_slt0", AluResult, 32'h0);
    cmp("r_slt_sel", {29'd0, AluSelect}, 32'd7);
    op(2'b10, 6'b101010, 32'hA, 32'hC, 1'b0); cmp("r_slt1", AluResult, 32'h1);

    op(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'h1, 1'b0); cmp("slt_neg", AluResult, 32'h1);
    op(2'b00, 6'd0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    cmp("wrap_res", AluResult, 32'h0);
    cmp("wrap_zero", {31'd0, Zero}, 32'd1);
    op(2'b01, 6'd0, 32'h8000_0000, 32'h1, 1'b0); cmp("sub_wrap", AluResult, 32'h7FFF_FFFF);

    op(2'b01, 6'd0, 32'd7, 32'd7, 1'b0);
    cmp("beq_nb_zero", {31'd0, Zero}, 32'd1);
    cmp("beq_nb_take", {31'd0, BranchSelect}, 32'd0);
    op(2'b01, 6'd0, 32'd7, 32'd7, 1'b1); cmp("beq_take", {31'd0, BranchSelect}, 32'd1);
    op(2'b01, 6'd0, 32'd7, 32'd8, 1'b1); cmp("beq_ne", {31'd0, BranchSelect}, 32'd0);

    op(2'b10, 6'b000000, 32'd3, 32'd4, 1'b0); cmp("def_fn", AluResult, 32'd7);
    op(2'b11, 6'b100010, 32'd3, 32'd4, 1'b0);
    cmp("def_op", AluResult, 32'd7);
    cmp("def_op_sel", {29'd0, AluSelect}, 32'd2);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      Reset = 1'b1;
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      if ($urandom_range(0, 4) == 0) a = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 31'd0} | (a & 32'h7);
      ALUOp = 2'($urandom_range(0, 3));
      InstrFunc = ($urandom_range(0, 5) == 0) ? 6'($urandom()) : fns[$urandom_range(0, 5)];
      SrcA = a; SrcB = b; Branch = 1'($urandom());
      if ($urandom_range(0, 40) == 0) begin
        #2;
        Reset = 1'b0;
      end
      @(posedge Clk);
      #1;
    end
    Reset = 1'b1;

    // Asynchronous reset mid-cycle must clear without a clock edge.
    op(2'b11, 6'd0, 32'd3, 32'd4, 1'b1);
    cmp("pre_async", AluResult, 32'd7);
    #1;
    Reset = 1'b0;
    #1;
    cmp("async_res", AluResult, 32'd0);
    cmp("async_sel", {29'd0, AluSelect}, 32'd0);
    cmp("async_zero", {31'd0, Zero}, 32'd0);
    cmp("async_take", {31'd0, BranchSelect}, 32'd0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
